exc_commit_ctrl: RTL and testbench
==================================

// Module: exc_commit_ctrl
// PURPOSE
//   Exception/interrupt commit controller at the MEM stage; the producer side of the CP0 exception interface.
//   - Collects per-instruction exception flags and synchronises the external interrupt lines.
//   - Evaluates interrupt enable from CP0 Status/Cause and selects one winning event per commit.
//   - Drives the one-hot flags, PC and bad address into cp0_reg.
//   - Flushes the pipeline and redirects fetch to the exception vector, or to EPC on ERET.
// PARAMETERS
//   EXC_VECTOR      32'hBFC00380  fetch target for every exception and interrupt
//   FLUSH_CYCLES    1             extra cycles flush_o is held after the commit cycle (1..15)
//   INT_SYNC_STAGES 2             flop stages on int_i before use (>=2)
// PORTS
//   clk             in   1   clock
//   rst             in   1   reset, synchronous, active-high
//   mem_valid_i     in   1   MEM holds a real, unsquashed instruction this cycle
//   mem_pc_i        in   32  PC of the MEM instruction
//   mem_addr_i      in   32  load/store effective address
//   mem_delayslot_i in   1   MEM instruction is in a branch delay slot
//   exc_adel_if_i   in   1   fetch address error
//   exc_ri_i        in   1   reserved instruction
//   exc_ov_i        in   1   arithmetic overflow
//   exc_sys_i       in   1   syscall
//   exc_bp_i        in   1   break
//   exc_adel_ld_i   in   1   load address error
//   exc_ades_i      in   1   store address error
//   eret_i          in   1   MEM instruction is ERET
//   int_i           in   6   asynchronous hardware interrupt lines IP7..IP2
//   timer_int_i     in   1   CP0 timer interrupt, ORed into IP7
//   cp0_status_i    in   32  CP0 Status (bit0 IE, bit1 EXL, [15:8] IM)
//   cp0_cause_i     in   32  CP0 Cause ([9:8] software IP)
//   cp0_epc_i       in   32  CP0 EPC
//   cp0_int_o       out  6   synchronised int_i, to CP0 Cause[15:10]
//   cp0_exc_int_o   out  1   interrupt taken
//   cp0_adel_o      out  1   AdEL taken (fetch or load)
//   cp0_ades_o      out  1   AdES taken
//   cp0_ri_o / cp0_ov_o / cp0_sys_o / cp0_bp_o  out 1 each  RI / Ov / Sys / Bp taken
//   cp0_eret_o      out  1   ERET committed
//   cp0_delayslot_o out  1   delay-slot flag of the committing instruction
//   cp0_pc_o        out  32  PC of the committing instruction (CP0 applies the -4 itself)
//   cp0_badvaddr_o  out  32  faulting address
//   flush_o         out  1   squash IF..MEM
//   redirect_o      out  1   one-cycle fetch redirect pulse
//   redirect_pc_o   out  32  redirect target
// BEHAVIOUR
//   Reset
//   - int sync chain = 0; state = IDLE; flush counter = 0.
//   - All outputs are forced to 0 while rst = 1.
//   Interrupt sync and pending
//   - cp0_int_o is the last stage of the sync chain; latency is INT_SYNC_STAGES cycles.
//   - pend[7:0] = {cp0_int_o[5] | timer_int_i, cp0_int_o[4:0], cp0_cause_i[9:8]}.
//   - int_req = IE & ~EXL & |(pend & IM).
//   Take condition
//   - An event is taken only when state = IDLE and mem_valid_i = 1.
//   - Interrupts attach to a valid instruction; they are never taken on a bubble.
//   Priority (highest first)
//   - int_req > adel_if > ri > ov > sys > bp > adel_ld > ades > eret.
//   - Exactly one cp0_*_o flag is high in a take cycle, and only for that cycle.
//   Commit outputs
//   - All commit outputs are combinational in the take cycle.
//   - cp0_pc_o = mem_pc_i; cp0_delayslot_o = mem_delayslot_i.
//   - cp0_badvaddr_o = mem_pc_i for adel_if, mem_addr_i for adel_ld/ades, otherwise 0.
//   - redirect_o = 1 in the take cycle.
//   - redirect_pc_o = cp0_epc_i for ERET, otherwise EXC_VECTOR.
//   - flush_o = 1 in the take cycle.
//   FSM
//   - IDLE --take--> FLUSH, with cnt = FLUSH_CYCLES.
//   - FLUSH: flush_o = 1, all inputs ignored (mem_valid_i, flags, int_req); cnt decrements; at cnt == 1 go to IDLE.
//   - Total flush_o width = 1 + FLUSH_CYCLES cycles.
//   - This covers the cycle in which CP0 EXL is not yet visible, so no double take.
//   Simultaneous and edge cases
//   - int_req plus any synchronous flag: interrupt wins; the instruction is not executed; EPC = its PC.
//   - Exception flag with eret_i: exception wins; cp0_eret_o = 0.
//   - mem_valid_i = 0 with flags set: nothing is taken and all outputs stay 0.
//   - rst during FLUSH: next cycle state = IDLE, flush_o = 0; the sync chain is cleared.
// TESTING
//   - sys at PC 0x80001000, no delay slot -> cp0_sys_o=1, cp0_pc_o=0x80001000, redirect_pc_o=0xBFC00380, flush_o high 2 cycles.
//   - int_i=6'b000100, Status=0x00001001 -> after 2 cycles, next valid instr gives cp0_exc_int_o=1; same with Status=0x00001003 -> no take.
//   - ov and int_req in the same cycle -> only cp0_exc_int_o=1; cp0_ov_o=0.
//   - load AdEL addr 0x80000003 at PC 0x80000100 -> cp0_adel_o=1, cp0_badvaddr_o=0x80000003; fetch AdEL -> badvaddr = PC.
//   - eret_i with cp0_epc_i=0x80002004 -> cp0_eret_o=1, redirect_pc_o=0x80002004; a sys flag in the next (FLUSH) cycle is ignored.
//   - rst asserted in the FLUSH cycle -> flush_o=0 next cycle; a following valid bp is taken normally.

Source files
------------

// File: rtl/exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// exc_commit_ctrl
//   Exception / interrupt commit controller sitting at the MEM stage. It is the
//   producer side of the CP0 exception interface.
//     - Synchronises the external interrupt lines and forms the pending vector
//       from them, the timer interrupt and the CP0 software interrupt bits.
//     - Picks one winning event per committing instruction
//       (int > adel_if > ri > ov > sys > bp > adel_ld > ades > eret).
//     - Drives one-hot taken flags, PC and bad address to cp0_reg in the take
//       cycle (combinational), flushes IF..MEM and redirects fetch to the
//       exception vector, or to EPC for ERET.
//     - After a take, holds flush for FLUSH_CYCLES more cycles. This also
//       covers the cycle in which CP0 EXL is not yet visible.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   mem_*_i               committing MEM-stage instruction: valid, PC,
//                         effective address, delay-slot flag
//   exc_*_i, eret_i       per-instruction exception flags and ERET marker
//   int_i, timer_int_i    asynchronous hardware interrupts, CP0 timer interrupt
//   cp0_status_i/cause_i  CP0 Status (IE, EXL, IM) and Cause (software IP)
//   cp0_epc_i             CP0 EPC, the ERET return target
//   cp0_int_o             synchronised int_i, to Cause[15:10]
//   cp0_*_o flags         one-hot taken event, valid for the take cycle only
//   cp0_delayslot_o       delay-slot flag of the committing instruction
//   cp0_pc_o              PC of the committing instruction
//   cp0_badvaddr_o        faulting address
//   flush_o               squash IF..MEM
//   redirect_o            one-cycle fetch redirect pulse
//   redirect_pc_o         redirect target
// -----------------------------------------------------------------------------
module exc_commit_ctrl #(
    parameter logic [31:0] EXC_VECTOR      = 32'hBFC00380,
    parameter int          FLUSH_CYCLES    = 1,
    parameter int          INT_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_addr_i,
    input  logic        mem_delayslot_i,
    input  logic        exc_adel_if_i,
    input  logic        exc_ri_i,
    input  logic        exc_ov_i,
    input  logic        exc_sys_i,
    input  logic        exc_bp_i,
    input  logic        exc_adel_ld_i,
    input  logic        exc_ades_i,
    input  logic        eret_i,
    input  logic [5:0]  int_i,
    input  logic        timer_int_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  cp0_int_o,
    output logic        cp0_exc_int_o,
    output logic        cp0_adel_o,
    output logic        cp0_ades_o,
    output logic        cp0_ri_o,
    output logic        cp0_ov_o,
    output logic        cp0_sys_o,
    output logic        cp0_bp_o,
    output logic        cp0_eret_o,
    output logic        cp0_delayslot_o,
    output logic [31:0] cp0_pc_o,
    output logic [31:0] cp0_badvaddr_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o
);

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    state_t                            state_q, state_d;
    logic [3:0]                        cnt_q, cnt_d;
    logic [INT_SYNC_STAGES-1:0][5:0]   int_sync_q;

    logic [5:0] int_sync;
    logic [7:0] pend;
    logic       int_req;
    logic       any_event;

    // Bits of Status/Cause that this block does not look at.
    logic unused_bits;
    assign unused_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                           cp0_cause_i[31:10], cp0_cause_i[7:0]};

    // Interrupt synchroniser: stage 0 captures int_i, the last stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            int_sync_q <= '0;
        end else begin
            int_sync_q <= {int_sync_q[INT_SYNC_STAGES-2:0], int_i};
        end
    end

    assign int_sync  = int_sync_q[INT_SYNC_STAGES-1];
    assign cp0_int_o = rst ? 6'd0 : int_sync;

    // Timer interrupt shares IP7 with the top external line.
    assign pend    = {int_sync[5] | timer_int_i, int_sync[4:0], cp0_cause_i[9:8]};
    assign int_req = cp0_status_i[0] & ~cp0_status_i[1] & (|(pend & cp0_status_i[15:8]));

    assign any_event = int_req | exc_adel_if_i | exc_ri_i | exc_ov_i | exc_sys_i |
                       exc_bp_i | exc_adel_ld_i | exc_ades_i | eret_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        cp0_exc_int_o   = 1'b0;
        cp0_adel_o      = 1'b0;
        cp0_ades_o      = 1'b0;
        cp0_ri_o        = 1'b0;
        cp0_ov_o        = 1'b0;
        cp0_sys_o       = 1'b0;
        cp0_bp_o        = 1'b0;
        cp0_eret_o      = 1'b0;
        cp0_delayslot_o = 1'b0;
        cp0_pc_o        = 32'd0;
        cp0_badvaddr_o  = 32'd0;
        flush_o         = 1'b0;
        redirect_o      = 1'b0;
        redirect_pc_o   = 32'd0;

        case (state_q)
            ST_IDLE: begin
                // Interrupts attach to a real instruction, never to a bubble.
                if (mem_valid_i && any_event) begin
                    state_d         = ST_FLUSH;
                    cnt_d           = FLUSH_INIT;
                    flush_o         = 1'b1;
                    redirect_o      = 1'b1;
                    redirect_pc_o   = EXC_VECTOR;
                    cp0_pc_o        = mem_pc_i;
                    cp0_delayslot_o = mem_delayslot_i;
                    if (int_req) begin
                        cp0_exc_int_o = 1'b1;
                    end else if (exc_adel_if_i) begin
                        cp0_adel_o     = 1'b1;
                        cp0_badvaddr_o = mem_pc_i;
                    end else if (exc_ri_i) begin
                        cp0_ri_o = 1'b1;
                    end else if (exc_ov_i) begin
                        cp0_ov_o = 1'b1;
                    end else if (exc_sys_i) begin
                        cp0_sys_o = 1'b1;
                    end else if (exc_bp_i) begin
                        cp0_bp_o = 1'b1;
                    end else if (exc_adel_ld_i) begin
                        cp0_adel_o     = 1'b1;
                        cp0_badvaddr_o = mem_addr_i;
                    end else if (exc_ades_i) begin
                        cp0_ades_o     = 1'b1;
                        cp0_badvaddr_o = mem_addr_i;
                    end else begin
                        cp0_eret_o    = 1'b1;
                        redirect_pc_o = cp0_epc_i;
                    end
                end
            end
            ST_FLUSH: begin
                // Inputs are ignored here; CP0 EXL may not be visible yet.
                flush_o = 1'b1;
                cnt_d   = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (rst) begin
            cp0_exc_int_o   = 1'b0;
            cp0_adel_o      = 1'b0;
            cp0_ades_o      = 1'b0;
            cp0_ri_o        = 1'b0;
            cp0_ov_o        = 1'b0;
            cp0_sys_o       = 1'b0;
            cp0_bp_o        = 1'b0;
            cp0_eret_o      = 1'b0;
            cp0_delayslot_o = 1'b0;
            cp0_pc_o        = 32'd0;
            cp0_badvaddr_o  = 32'd0;
            flush_o         = 1'b0;
            redirect_o      = 1'b0;
            redirect_pc_o   = 32'd0;
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_exc_commit_ctrl
//   Scoreboard bench for exc_commit_ctrl. The stimulus side drives one cycle
//   of inputs, asks the reference model what the outputs must be during that
//   cycle and queues the answer; the monitor pops one entry per cycle on the
//   falling edge and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_exc_commit_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam int          FC  = 1;
    localparam int          NS  = 2;

    logic        clk;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic [31:0] mem_addr_i;
    logic        mem_delayslot_i;
    logic        exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i, exc_bp_i;
    logic        exc_adel_ld_i, exc_ades_i, eret_i;
    logic [5:0]  int_i;
    logic        timer_int_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic [5:0]  cp0_int_o;
    logic        cp0_exc_int_o, cp0_adel_o, cp0_ades_o, cp0_ri_o, cp0_ov_o;
    logic        cp0_sys_o, cp0_bp_o, cp0_eret_o, cp0_delayslot_o;
    logic [31:0] cp0_pc_o, cp0_badvaddr_o;
    logic        flush_o, redirect_o;
    logic [31:0] redirect_pc_o;

    exc_commit_ctrl #(
        .EXC_VECTOR     (VEC),
        .FLUSH_CYCLES   (FC),
        .INT_SYNC_STAGES(NS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid_i    (mem_valid_i),
        .mem_pc_i       (mem_pc_i),
        .mem_addr_i     (mem_addr_i),
        .mem_delayslot_i(mem_delayslot_i),
        .exc_adel_if_i  (exc_adel_if_i),
        .exc_ri_i       (exc_ri_i),
        .exc_ov_i       (exc_ov_i),
        .exc_sys_i      (exc_sys_i),
        .exc_bp_i       (exc_bp_i),
        .exc_adel_ld_i  (exc_adel_ld_i),
        .exc_ades_i     (exc_ades_i),
        .eret_i         (eret_i),
        .int_i          (int_i),
        .timer_int_i    (timer_int_i),
        .cp0_status_i   (cp0_status_i),
        .cp0_cause_i    (cp0_cause_i),
        .cp0_epc_i      (cp0_epc_i),
        .cp0_int_o      (cp0_int_o),
        .cp0_exc_int_o  (cp0_exc_int_o),
        .cp0_adel_o     (cp0_adel_o),
        .cp0_ades_o     (cp0_ades_o),
        .cp0_ri_o       (cp0_ri_o),
        .cp0_ov_o       (cp0_ov_o),
        .cp0_sys_o      (cp0_sys_o),
        .cp0_bp_o       (cp0_bp_o),
        .cp0_eret_o     (cp0_eret_o),
        .cp0_delayslot_o(cp0_delayslot_o),
        .cp0_pc_o       (cp0_pc_o),
        .cp0_badvaddr_o (cp0_badvaddr_o),
        .flush_o        (flush_o),
        .redirect_o     (redirect_o),
        .redirect_pc_o  (redirect_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags order: {int, adel, ades, ri, ov, sys, bp, eret}
    typedef struct packed {
        logic [5:0]  ci;
        logic [7:0]  flags;
        logic        ds;
        logic [31:0] pc;
        logic [31:0] bad;
        logic        flush;
        logic        redir;
        logic [31:0] rpc;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] int_hist[$];   // int_i values still travelling to cp0_int_o
    int         busy;          // flush cycles still owed after a take
    int         checks;
    int         errors;
    int         cycle;
    exp_t       mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // Reference model: outputs owed for the inputs currently applied.
    function automatic exp_t model(output logic take);
        exp_t       e;
        logic [7:0] pend;
        logic       ireq;
        logic       req[9];
        int         win;
        e    = '0;
        take = 1'b0;
        if (!rst) begin
            e.ci = int_hist[0];
            if (busy > 0) begin
                e.flush = 1'b1;
            end else if (mem_valid_i) begin
                pend = {int_hist[0][5] | timer_int_i, int_hist[0][4:0], cp0_cause_i[9:8]};
                ireq = cp0_status_i[0] && !cp0_status_i[1] && ((pend & cp0_status_i[15:8]) != 8'd0);
                req  = '{ireq, exc_adel_if_i, exc_ri_i, exc_ov_i, exc_sys_i,
                         exc_bp_i, exc_adel_ld_i, exc_ades_i, eret_i};
                win = -1;
                for (int k = 0; k < 9; k++) begin
                    if (req[k] && win < 0) win = k;
                end
                if (win >= 0) begin
                    take    = 1'b1;
                    e.flush = 1'b1;
                    e.redir = 1'b1;
                    e.pc    = mem_pc_i;
                    e.ds    = mem_delayslot_i;
                    e.rpc   = (win == 8) ? cp0_epc_i : VEC;
                    case (win)
                        0: e.flags = 8'b1000_0000;
                        1: begin e.flags = 8'b0100_0000; e.bad = mem_pc_i; end
                        2: e.flags = 8'b0001_0000;
                        3: e.flags = 8'b0000_1000;
                        4: e.flags = 8'b0000_0100;
                        5: e.flags = 8'b0000_0010;
                        6: begin e.flags = 8'b0100_0000; e.bad = mem_addr_i; end
                        7: begin e.flags = 8'b0010_0000; e.bad = mem_addr_i; end
                        default: e.flags = 8'b0000_0001;
                    endcase
                end
            end
        end
        return e;
    endfunction

    // Apply the current inputs for one clock cycle.
    task automatic cyc();
        logic take;
        exp_t e;
        e = model(take);
        sb.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        if (rst) begin
            int_hist.delete();
            for (int k = 0; k < NS; k++) int_hist.push_back(6'd0);
            busy = 0;
        end else begin
            int_hist.delete(0);
            int_hist.push_back(int_i);
            if (busy > 0) busy--;
            else if (take) busy = FC;
        end
    endtask

    task automatic quiet();
        mem_valid_i     = 1'b0;
        mem_delayslot_i = 1'b0;
        exc_adel_if_i   = 1'b0;
        exc_ri_i        = 1'b0;
        exc_ov_i        = 1'b0;
        exc_sys_i       = 1'b0;
        exc_bp_i        = 1'b0;
        exc_adel_ld_i   = 1'b0;
        exc_ades_i      = 1'b0;
        eret_i          = 1'b0;
    endtask

    // Monitor: one transaction per cycle, compared on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("cp0_int", {26'd0, cp0_int_o}, {26'd0, mon_e.ci});
                chk("flags", {24'd0, cp0_exc_int_o, cp0_adel_o, cp0_ades_o, cp0_ri_o,
                              cp0_ov_o, cp0_sys_o, cp0_bp_o, cp0_eret_o}, {24'd0, mon_e.flags});
                chk("delayslot", {31'd0, cp0_delayslot_o}, {31'd0, mon_e.ds});
                chk("cp0_pc", cp0_pc_o, mon_e.pc);
                chk("badvaddr", cp0_badvaddr_o, mon_e.bad);
                chk("flush", {31'd0, flush_o}, {31'd0, mon_e.flush});
                chk("redirect", {31'd0, redirect_o}, {31'd0, mon_e.redir});
                chk("redirect_pc", redirect_pc_o, mon_e.rpc);
                if (mon_e.redir)
                    $display("commit cycle %0d pc %h flags %b badvaddr %h target %h",
                             cycle, mon_e.pc, mon_e.flags, mon_e.bad, mon_e.rpc);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        busy   = 0;
        for (int k = 0; k < NS; k++) int_hist.push_back(6'd0);
        rst          = 1'b1;
        quiet();
        mem_pc_i     = 32'd0;
        mem_addr_i   = 32'd0;
        int_i        = 6'd0;
        timer_int_i  = 1'b0;
        cp0_status_i = 32'd0;
        cp0_cause_i  = 32'd0;
        cp0_epc_i    = 32'd0;
        @(posedge clk);
        #1;

        // Reset with activity on the inputs: everything must stay 0.
        mem_valid_i = 1'b1; exc_sys_i = 1'b1; int_i = 6'h3F;
        cp0_status_i = 32'h0000FF01;
        cyc(); cyc(); cyc();
        rst = 1'b0; quiet(); int_i = 6'd0; cp0_status_i = 32'd0;
        cyc(); cyc();

        // Syscall: flush for two cycles, redirect to the vector.
        mem_valid_i = 1'b1; exc_sys_i = 1'b1; mem_pc_i = 32'h80001000;
        cyc();
        quiet(); cyc(); cyc();

        // Interrupt on IP4 with IE=1 after synchronisation.
        cp0_status_i = 32'h00001001; int_i = 6'b000100;
        cyc(); cyc();
        mem_valid_i = 1'b1; mem_pc_i = 32'h80000200;
        cyc();
        quiet(); cyc();
        // Same with EXL set: no take.
        cp0_status_i = 32'h00001003; mem_valid_i = 1'b1; mem_pc_i = 32'h80000204;
        cyc();
        quiet(); cyc();

        // Overflow and interrupt together: interrupt wins.
        cp0_status_i = 32'h00001001; mem_valid_i = 1'b1; exc_ov_i = 1'b1;
        mem_pc_i = 32'h80000300; mem_delayslot_i = 1'b1;
        cyc();
        quiet(); int_i = 6'd0; cp0_status_i = 32'd0; cyc(); cyc(); cyc();

        // Load address error, then fetch address error.
        mem_valid_i = 1'b1; exc_adel_ld_i = 1'b1;
        mem_pc_i = 32'h80000100; mem_addr_i = 32'h80000003;
        cyc();
        quiet(); cyc();
        mem_valid_i = 1'b1; exc_adel_if_i = 1'b1; mem_pc_i = 32'h80000101;
        cyc();
        quiet(); cyc();

        // ERET, then a syscall during the flush cycle is ignored.
        mem_valid_i = 1'b1; eret_i = 1'b1; cp0_epc_i = 32'h80002004; mem_pc_i = 32'h80000400;
        cyc();
        quiet(); mem_valid_i = 1'b1; exc_sys_i = 1'b1; cyc();
        quiet(); cyc();

        // Exception with ERET: exception wins.
        mem_valid_i = 1'b1; eret_i = 1'b1; exc_bp_i = 1'b1;
        cyc();
        quiet(); cyc();

        // Flags on a bubble: nothing taken.
        exc_ri_i = 1'b1; exc_ades_i = 1'b1; eret_i = 1'b1;
        cyc();
        quiet(); cyc();

        // Reset during the flush cycle, then a break is taken normally.
        mem_valid_i = 1'b1; exc_sys_i = 1'b1; mem_pc_i = 32'h80000500;
        cyc();
        quiet(); rst = 1'b1; cyc();
        rst = 1'b0; mem_valid_i = 1'b1; exc_bp_i = 1'b1; mem_pc_i = 32'h80000504;
        cyc();
        quiet(); cyc();

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            mem_valid_i     = ($urandom_range(0, 1) == 1);
            mem_pc_i        = $urandom;
            mem_addr_i      = $urandom;
            mem_delayslot_i = ($urandom_range(0, 3) == 0);
            exc_adel_if_i   = ($urandom_range(0, 15) == 0);
            exc_ri_i        = ($urandom_range(0, 15) == 0);
            exc_ov_i        = ($urandom_range(0, 15) == 0);
            exc_sys_i       = ($urandom_range(0, 15) == 0);
            exc_bp_i        = ($urandom_range(0, 15) == 0);
            exc_adel_ld_i   = ($urandom_range(0, 15) == 0);
            exc_ades_i      = ($urandom_range(0, 15) == 0);
            eret_i          = ($urandom_range(0, 7) == 0);
            int_i           = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            timer_int_i     = ($urandom_range(0, 15) == 0);
            cp0_status_i    = {$urandom_range(0, 65535)} << 16;
            cp0_status_i[15:8] = 8'($urandom);
            cp0_status_i[7:2]  = 6'($urandom);
            cp0_status_i[1]    = ($urandom_range(0, 7) == 0);
            cp0_status_i[0]    = ($urandom_range(0, 3) != 0);
            cp0_cause_i     = $urandom;
            if ($urandom_range(0, 3) != 0) cp0_cause_i[9:8] = 2'b00;
            cp0_epc_i       = $urandom;
            cyc();
        end

        rst = 1'b0; quiet(); cyc();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
